regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the single-cycle writeback path (wb);
  - a late load-return path (ld), which arrives decoupled from the instruction.
- Load returns are buffered in a small queue.
- Fixed priority goes to wb, with a starvation limit that guarantees ld progress.
- Sits between the core datapath and the register file write port (reg_write / write_reg / write_data).

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- Q_DEPTH, 4, load-return queue entries (power of 2, at least 2)
- STARVE_LIMIT, 3, consecutive cycles a non-empty queue may lose arbitration before ld is forced

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  writeback request
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback data
- wb_ready  output  1  wb request granted this cycle (combinational)
- ld_valid  input  1  load-return request
- ld_addr  input  ADDR_W  load destination
- ld_data  input  DATA_W  load data
- ld_ready  output  1  queue can accept (not full)
- rf_we  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_W  register file write address (registered)
- rf_wdata  output  DATA_W  register file write data (registered)
- q_count  output  $clog2(Q_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Queue empty: q_count=0, ld_ready=1.
  - starve_cnt=0.
- Enqueue:
  - ld_valid && ld_ready at edge N pushes {ld_addr, ld_data}.
  - The entry is visible at the queue head from cycle N+1; there is no same-cycle bypass.
- ld_ready = (q_count != Q_DEPTH).
  - A push and a pop in the same cycle when full is not allowed, because ld_ready is already 0.
- Arbitration, evaluated each cycle between wb and the queue head (hv = queue non-empty):
  - force_ld = hv && (starve_cnt == STARVE_LIMIT).
  - order_ld = hv && wb_valid && (head.addr == wb_addr) && wb_addr != 0. The older load must land before the newer writeback to the same register.
  - grant_ld = hv && (force_ld || order_ld || !wb_valid).
  - grant_wb = wb_valid && !grant_ld.
  - wb_ready = grant_wb.
- starve_cnt:
  - Cleared on grant_ld or when the queue is empty.
  - Incremented when hv && !grant_ld.
  - Saturates at STARVE_LIMIT.
- Write port timing:
  - rf_we/rf_waddr/rf_wdata are registered and valid in cycle N+1 after the grant in cycle N.
  - Result: wb latency is 1 cycle; ld latency is at least 2 cycles.
- Writes to x0:
  - A granted request with addr==0 is consumed (pop / wb_ready), but rf_we stays 0 that cycle.
  - rf_waddr/rf_wdata may still update.
- No grant: rf_we=0 next cycle; rf_waddr/rf_wdata hold their values.
- Simultaneous push and pop (not full): q_count is unchanged.
- Pointers wrap modulo Q_DEPTH.
- Reset mid-operation: queued entries are discarded and no write is issued; rf_we drops immediately (async).

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- With the macro defined:
  - Adds output ports wb_grant_cnt [15:0] and ld_grant_cnt [15:0].
  - Each counts grants, including x0 grants.
  - Each saturates at 16'hFFFF.
  - Both reset to 0.
- Without the macro: the ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package rf_arb_pkg:
  - DATA_W/ADDR_W defaults.
  - typedef rf_wr_req_t (struct packed {addr, data}).
  - Localparam X0_ADDR = 0.
- Sub-module rf_arb_fifo:
  - Synchronous FIFO of rf_wr_req_t, Q_DEPTH entries.
  - Ports: push, pop, head, count, full, empty.
  - Asynchronous active-low reset.
- The arbiter, starve counter and output register stay in the top module.

Test Plan:
- After reset, wb_valid=1, wb_addr=5, wb_data=32'hDEAD_BEEF for one cycle -> wb_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF.
- Single ld push addr=7, data=32'h1234 with wb idle -> q_count=1 at N+1; grant at N+1; rf_we=1, rf_waddr=7 at N+2; q_count returns to 0.
- Starvation:
  - Stimulus: wb_valid held high (addr=3) continuously, ld push addr=9.
  - Required: wb wins 3 cycles; on the 4th cycle wb_ready=0 and rf_waddr=9 one cycle later; starve_cnt back to 0.
- Ordering: queue head addr=4 and wb_valid with wb_addr=4 in the same cycle -> ld granted first (wb_ready=0), rf write addr=4 ld data, then wb data the following cycle.
- x0 drop: ld push addr=0 and wb addr=0 -> both consumed, q_count returns to 0, rf_we never asserted.
- Full / reset:
  - Push 4 loads while wb_valid stays high -> ld_ready=0 at q_count=4.
  - Then assert rst_n=0 mid-stream -> rf_we=0 immediately, q_count=0, ld_ready=1.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int X0_ADDR    = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO buffering load-return write requests.
// Head is read combinationally, and a push is not visible at the head until the next cycle.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rf_wr_req_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and queued load returns,
// with a starvation limit for loads. Define RF_ARB_STATS_EN to add saturating grant counters.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int Q_DEPTH      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(Q_DEPTH):0] q_count
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]              wb_grant_cnt,
  output logic [15:0]              ld_grant_cnt
`endif
);

  localparam int                SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(X0_ADDR);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t          push_req;
  req_t          head;
  logic          q_full;
  logic          q_empty;
  logic          hv;
  logic          force_ld;
  logic          order_ld;
  logic          grant_ld;
  logic          grant_wb;
  logic [SW-1:0] starve_cnt;

  assign push_req = '{addr: ld_addr, data: ld_data};
  assign ld_ready = !q_full;

  rf_arb_fifo #(
    .DEPTH (Q_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ld_valid && ld_ready),
    .wdata (push_req),
    .pop   (grant_ld),
    .head  (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // The queued load is older than any writeback presented now, so a same-register
  // collision must let the load land first to keep the final value correct.
  assign hv       = !q_empty;
  assign force_ld = hv && (starve_cnt == STARVE_MAX);
  assign order_ld = hv && wb_valid && (head.addr == wb_addr) && (wb_addr != ZERO_ADDR);
  assign grant_ld = hv && (force_ld || order_ld || !wb_valid);
  assign grant_wb = wb_valid && !grant_ld;
  assign wb_ready = grant_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!hv || grant_ld) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Write-port register: grants in cycle N appear on the register file in N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (grant_ld && head.addr != ZERO_ADDR) || (grant_wb && wb_addr != ZERO_ADDR);
      if (grant_ld) begin
        rf_waddr <= head.addr;
        rf_wdata <= head.data;
      end else if (grant_wb) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_grant_cnt <= '0;
      ld_grant_cnt <= '0;
    end else begin
      if (grant_wb && wb_grant_cnt != 16'hFFFF) wb_grant_cnt <= wb_grant_cnt + 1'b1;
      if (grant_ld && ld_grant_cnt != 16'hFFFF) ld_grant_cnt <= ld_grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (default build, stats disabled).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_ready (wb_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .q_count  (q_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    #12;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", rf_we); end
    tests++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    tests++; if (rf_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL reset_ldready: got %b want 1", ld_ready); end
    tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL reset_wbready: got %b want 0", wb_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wb();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL wb_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL wb_we: got %b want 1", rf_we); end
    tests++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL wb_waddr: got %0d want 5", rf_waddr); end
    tests++; if (rf_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wb_wdata: got %h want deadbeef", rf_wdata); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL idle_we: got %b want 0", rf_we); end
    tests++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL idle_hold_waddr: got %0d want 5", rf_waddr); end
  endtask

  task automatic test_ld_single();
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234;
    #1;
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL ld_no_bypass: got q_count %0d want 0", q_count); end
    tick();
    ld_valid = 1'b0;
    tests++; if (q_count !== 3'd1) begin fails++; $display("FAIL ld_qcount1: got %0d want 1", q_count); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL ld_we_early: got %b want 0", rf_we); end
    tick();
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL ld_we: got %b want 1", rf_we); end
    tests++; if (rf_waddr !== 5'd7) begin fails++; $display("FAIL ld_waddr: got %0d want 7", rf_waddr); end
    tests++; if (rf_wdata !== 32'h1234) begin fails++; $display("FAIL ld_wdata: got %h want 1234", rf_wdata); end
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL ld_qcount0: got %0d want 0", q_count); end
    tick();
  endtask

  task automatic test_starvation();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333;
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h9999;
    tick();
    ld_valid = 1'b0;
    tests++; if (q_count !== 3'd1) begin fails++; $display("FAIL starve_qcount: got %0d want 1", q_count); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL starve_wb_win%0d: got %b want 1", i, wb_ready); end
      tick();
      tests++; if (rf_waddr !== 5'd3) begin fails++; $display("FAIL starve_wb_addr%0d: got %0d want 3", i, rf_waddr); end
    end
    tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL starve_force: got wb_ready %b want 0", wb_ready); end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999) begin
      fails++; $display("FAIL starve_ld_write: got we=%b addr=%0d data=%h want we=1 addr=9 data=9999", rf_we, rf_waddr, rf_wdata);
    end
    tests++; if (dut.starve_cnt !== 2'd0) begin fails++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
    tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL starve_wb_resume: got %b want 1", wb_ready); end
    wb_valid = 1'b0;
    tick();
  endtask

  task automatic test_ordering();
    ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h4444;
    tick();
    ld_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4B4B;
    #1;
    tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL order_wb_blocked: got %b want 0", wb_ready); end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4444) begin
      fails++; $display("FAIL order_ld_first: got we=%b addr=%0d data=%h want we=1 addr=4 data=4444", rf_we, rf_waddr, rf_wdata);
    end
    tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL order_wb_next: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4B4B) begin
      fails++; $display("FAIL order_wb_second: got we=%b addr=%0d data=%h want we=1 addr=4 data=4b4b", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_x0();
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h5555;
    tick();
    ld_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h6666;
    #1;
    tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL x0_wb_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_wb_we: got %b want 0", rf_we); end
    tests++; if (q_count !== 3'd1) begin fails++; $display("FAIL x0_qcount1: got %0d want 1", q_count); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_ld_we: got %b want 0", rf_we); end
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL x0_qcount0: got %0d want 0", q_count); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_after_we: got %b want 0", rf_we); end
  endtask

  task automatic test_full_reset();
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hAAAA;
    ld_valid = 1'b1; ld_data = 32'hC0DE;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 5'(11 + i);
      tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL full_ready%0d: got %b want 1", i, ld_ready); end
      tick();
    end
    ld_valid = 1'b0;
    tests++; if (q_count !== 3'd4) begin fails++; $display("FAIL full_qcount: got %0d want 4", q_count); end
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL full_ldready: got %b want 0", ld_ready); end
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL full_prereset_we: got %b want 1", rf_we); end
    rst_n = 1'b0;
    #1;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_async_we: got %b want 0", rf_we); end
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL rst_qcount: got %0d want 0", q_count); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL rst_ldready: got %b want 1", ld_ready); end
    wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_no_write: got %b want 0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_wb();
    test_ld_single();
    test_starvation();
    test_ordering();
    test_x0();
    test_full_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
